spi_packet_scheduler: RTL

Sequences the downsampled camera pixel stream onto the 6-line parallel SPI sender. Accepts full-resolution pixels after blur and clock-domain crossing, keeps every other pixel of every other row, and packs pixels into LINES-wide packets. Holds one completed packet while the SPI sender is busy and inserts a start-of-frame sync packet so the receiving FPGA can align frames. Counts packets dropped to backpressure. Sits between the second CDC FIFO and spi_send_con, in the clk_100mhz domain.

---
 rtl/spi_packet_scheduler.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_packet_scheduler.sv
// spi_packet_scheduler
//
// Purpose:
//   Downsamples the camera pixel stream and feeds it to the parallel SPI
//   sender. Only pixels with an even column and an even row are kept. Kept
//   pixels are packed LINES at a time into packets. One completed packet is
//   held while the sender is busy. A sync packet (SYNC_WORD on every line) is
//   sent at each start of frame. Data packets that cannot be held are dropped
//   and counted.
//
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous, active-high reset
//   pixel_valid_in  pixel/hcount/vcount are valid this cycle
//   pixel_data_in   RGB565 pixel
//   hcount_in       pixel column
//   vcount_in       pixel row
//   spi_busy_in     high while the sender is shifting a packet
//   data_out        packet to the sender; line i = [i*DATA_WIDTH +: DATA_WIDTH]
//   trigger_out     one-cycle start pulse to the sender
//   sof_out         high together with trigger_out for a sync packet
//   drop_count_out  saturating count of dropped data packets
//
// Sender handshake:
//   trigger_out is a single-cycle request, and data_out/sof_out are valid
//   with it. After a trigger the block waits for spi_busy_in to rise, which
//   acknowledges the start. It then waits for spi_busy_in to fall, which
//   marks the end of the transfer. Only then may the next trigger be issued.
//   data_out holds its value from one trigger until the next.
module spi_packet_scheduler #(
    parameter int                    LINES      = 6,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    HRES       = 1280,
    parameter int                    VRES       = 720,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD  = 16'hA5A5
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          pixel_valid_in,
    input  logic [DATA_WIDTH-1:0]         pixel_data_in,
    input  logic [10:0]                   hcount_in,
    input  logic [9:0]                    vcount_in,
    input  logic                          spi_busy_in,
    output logic [LINES*DATA_WIDTH-1:0]   data_out,
    output logic                          trigger_out,
    output logic                          sof_out,
    output logic [15:0]                   drop_count_out
);

    localparam int                IDX_W    = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINES - 1);
    localparam logic [10:0]       HRES_L   = 11'(HRES);
    localparam logic [9:0]        VRES_L   = 10'(VRES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_WAIT_DONE
    } state_t;

    typedef logic [LINES-1:0][DATA_WIDTH-1:0] packet_t;

    state_t                      state_q, state_d;
    packet_t                     asm_q, asm_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    packet_t                     hold_q, hold_d;
    logic                        hold_full_q, hold_full_d;
    logic                        sync_pending_q, sync_pending_d;
    logic [LINES*DATA_WIDTH-1:0] data_q, data_d;
    logic                        trigger_q, trigger_d;
    logic                        sof_q, sof_d;
    logic [15:0]                 drop_q, drop_d;

    // Pixel intake.
    logic                        accept;
    logic                        sof_pix;
    logic [DATA_WIDTH-1:0]       pix;
    logic [IDX_W-1:0]            slot;
    logic                        complete;
    packet_t                     pkt;

    always_comb begin
        accept  = pixel_valid_in && !hcount_in[0] && !vcount_in[0] &&
                  (hcount_in < HRES_L) && (vcount_in < VRES_L);
        sof_pix = accept && (hcount_in == 11'd0) && (vcount_in == 10'd0);
        // A pixel equal to the sync word is altered so that a sync pattern
        // can only ever appear in a real sync packet.
        pix     = (pixel_data_in == SYNC_WORD) ?
                  (SYNC_WORD ^ DATA_WIDTH'(1)) : pixel_data_in;
        // Start of frame restarts assembly at slot 0. The stale partial
        // contents of the other slots are overwritten before the packet can
        // complete.
        slot    = sof_pix ? '0 : idx_q;
        complete = accept && (slot == LAST_IDX);
        pkt       = asm_q;
        pkt[slot] = pix;
    end

    // Launch decisions.
    logic launch_sync;
    logic launch_hold;
    logic launch_bypass;
    logic idle_free;

    always_comb begin
        idle_free     = (state_q == ST_IDLE) && !spi_busy_in;
        launch_sync   = idle_free && sync_pending_q;
        launch_hold   = idle_free && !sync_pending_q && hold_full_q;
        // A packet completing while nothing is pending goes straight out.
        // This gives the one-cycle trigger latency without a pass through
        // the hold buffer.
        launch_bypass = idle_free && !sync_pending_q && !hold_full_q &&
                        complete && !sof_pix;
    end

    // Next-state logic.
    always_comb begin
        state_d        = state_q;
        asm_d          = asm_q;
        idx_d          = idx_q;
        hold_d         = hold_q;
        hold_full_d    = hold_full_q;
        sync_pending_d = sync_pending_q;
        data_d         = data_q;
        trigger_d      = 1'b0;
        sof_d          = 1'b0;
        drop_d         = drop_q;

        // Assembly.
        if (accept) begin
            asm_d = pkt;
            idx_d = complete ? '0 : (slot + IDX_W'(1));
        end

        // Hold buffer and drop accounting. The hold buffer can accept a
        // packet when it is empty or when it is being launched this cycle.
        if (launch_hold) begin
            hold_full_d = 1'b0;
        end
        if (complete && !launch_bypass) begin
            if (!hold_full_q || launch_hold) begin
                hold_d      = pkt;
                hold_full_d = 1'b1;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end

        // Sync request. The clear comes first, so a start of frame arriving in
        // the same cycle as a sync launch leaves a fresh sync pending.
        if (launch_sync) begin
            sync_pending_d = 1'b0;
        end
        if (sof_pix) begin
            sync_pending_d = 1'b1;
        end

        // Sender FSM.
        case (state_q)
            ST_IDLE: begin
                if (launch_sync) begin
                    data_d    = {LINES{SYNC_WORD}};
                    trigger_d = 1'b1;
                    sof_d     = 1'b1;
                    state_d   = ST_WAIT_START;
                end else if (launch_hold) begin
                    data_d    = hold_q;
                    trigger_d = 1'b1;
                    state_d   = ST_WAIT_START;
                end else if (launch_bypass) begin
                    data_d    = pkt;
                    trigger_d = 1'b1;
                    state_d   = ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                if (spi_busy_in) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!spi_busy_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= ST_IDLE;
            asm_q          <= '0;
            idx_q          <= '0;
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            sync_pending_q <= 1'b0;
            data_q         <= '0;
            trigger_q      <= 1'b0;
            sof_q          <= 1'b0;
            drop_q         <= '0;
        end else begin
            state_q        <= state_d;
            asm_q          <= asm_d;
            idx_q          <= idx_d;
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            sync_pending_q <= sync_pending_d;
            data_q         <= data_d;
            trigger_q      <= trigger_d;
            sof_q          <= sof_d;
            drop_q         <= drop_d;
        end
    end

    assign data_out       = data_q;
    assign trigger_out    = trigger_q;
    assign sof_out        = sof_q;
    assign drop_count_out = drop_q;

endmodule
